// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with single-cycle ops and iterative shift-add MUL.
// Define ALU_DIV_EN to also build the restoring DIVU (code 1010).
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cnt,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             err,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; the producer holds its payload stable until that edge.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] op_a, op_b, acc;
  logic             is_div, div_zero;

  logic [WIDTH-1:0] sum, diff, simple_res;
  logic             simple_ovf, simple_err, iter, accept;
  logic [WIDTH-1:0] next_a, next_b, next_acc, final_res;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_shift, rem_diff;
`endif

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign state_dbg = state;

  always_comb begin
    sum        = src_a + src_b;
    diff       = src_a - src_b;
    simple_res = '0;
    simple_ovf = 1'b0;
    simple_err = 1'b0;
    iter       = 1'b0;
    case (alu_cnt)
      4'b0000: begin
        simple_res = sum;
        simple_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0001: begin
        simple_res = diff;
        simple_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0010: simple_res = src_a & src_b;
      4'b0011: simple_res = src_a | src_b;
      4'b0100: simple_res = src_a ^ src_b;
      4'b0101: simple_res = (int'(src_b[4:0]) >= WIDTH) ? '0 : (src_a << src_b[4:0]);
      4'b0110: simple_res = (int'(src_b[4:0]) >= WIDTH) ? '0 : (src_a >> src_b[4:0]);
      4'b0111: simple_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b1000: iter = 1'b1;
`ifdef ALU_DIV_EN
      4'b1010: iter = 1'b1;
`endif
      default: simple_err = 1'b1;
    endcase
  end

  // One iteration step; op_a/op_b/acc hold multiplicand/multiplier/product,
  // or quotient-in-progress/divisor/remainder for DIVU.
  always_comb begin
    next_acc  = op_b[0] ? (acc + op_a) : acc;
    next_a    = op_a << 1;
    next_b    = op_b >> 1;
    final_res = next_acc;
`ifdef ALU_DIV_EN
    rem_shift = {acc, op_a[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, op_b};
    if (is_div) begin
      next_b = op_b;
      if (!rem_diff[WIDTH]) begin
        next_acc = rem_diff[WIDTH-1:0];
        next_a   = {op_a[WIDTH-2:0], 1'b1};
      end else begin
        next_acc = rem_shift[WIDTH-1:0];
        next_a   = {op_a[WIDTH-2:0], 1'b0};
      end
      final_res = next_a;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          op_a  <= next_a;
          op_b  <= next_b;
          acc   <= next_acc;
          count <= count - 1'b1;
          if (count == '0) begin
            state    <= DONE;
            result   <= final_res;
            zero     <= (final_res == '0);
            overflow <= 1'b0;
            err      <= is_div && div_zero;
          end
        end
        default: begin
          if (accept) begin
            if (iter) begin
              state    <= CALC;
              op_a     <= src_a;
              op_b     <= src_b;
              acc      <= '0;
              count    <= CW'(WIDTH - 1);
              is_div   <= (alu_cnt == 4'b1010);
              div_zero <= (src_b == '0);
            end else begin
              state    <= DONE;
              result   <= simple_res;
              zero     <= (simple_res == '0);
              overflow <= simple_ovf;
              err      <= simple_err;
            end
          end else if ((state != DONE) || out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: vector table plus handshake/reset corner sequences.
// DIVU vectors are used when ALU_DIV_EN is defined.
module tb_alu_exec_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_cnt = '0;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, overflow, err, busy;
  logic [1:0]   state_dbg;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cnt(alu_cnt), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow),
    .err(err), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] a, b, res;
    logic         z, ovf, e;
  } vec_t;

  vec_t         vecs[$];
  logic [W+2:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add_vec(input logic [3:0] c, input logic [W-1:0] a, b, r,
                         input logic z, ovf, e);
    vec_t v;
    v.code = c; v.a = a; v.b = b; v.res = r; v.z = z; v.ovf = ovf; v.e = e;
    vecs.push_back(v);
  endtask

  function automatic int exp_latency(input logic [3:0] c);
`ifdef ALU_DIV_EN
    if (c == 4'b1010) return W + 1;
`endif
    return (c == 4'b1000) ? W + 1 : 1;
  endfunction

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic drive_op(input logic [3:0] c, input logic [W-1:0] a, b);
    int guard = 0;
    alu_cnt = c; src_a = a; src_b = b; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic score(input string name);
    logic [W+2:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_result"},   result,   e[W+2:3]);
    check({name, "_zero"},     zero,     e[2]);
    check({name, "_overflow"}, overflow, e[1]);
    check({name, "_err"},      err,      e[0]);
  endtask

  // Waits (bounded) for out_valid, scores it, checks latency, lets it drain.
  task automatic collect(input string name, input int start_lat, input int exp_lat);
    int lat = start_lat;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_latency"}, lat, exp_lat);
    if (out_valid) score(name);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_result", result, 0);
    check("reset_flags", {zero, overflow, err}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table
    add_vec(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0);
    add_vec(4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 0);
    add_vec(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0, 0);
    add_vec(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 0);
    add_vec(4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0);
    add_vec(4'b0011, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0, 0);
    add_vec(4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 0, 0, 0);
    add_vec(4'b0101, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 0, 0, 0);
    add_vec(4'b0110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 0, 0, 0);
    add_vec(4'b0110, 32'h8000_0000, 32'h0000_0020, 32'h8000_0000, 0, 0, 0);
    add_vec(4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 0);
    add_vec(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0);
    add_vec(4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 0, 1);
    add_vec(4'b1000, 32'h0001_0003, 32'h0000_0004, 32'h0004_000C, 0, 0, 0);
    add_vec(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0);
`ifdef ALU_DIV_EN
    add_vec(4'b1010, 32'd100, 32'd7, 32'd14, 0, 0, 0);
    add_vec(4'b1010, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 1);
`else
    add_vec(4'b1010, 32'd100, 32'd7, 32'h0000_0000, 1, 0, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back({vecs[i].res, vecs[i].z, vecs[i].ovf, vecs[i].e});
      drive_op(vecs[i].code, vecs[i].a, vecs[i].b);
      collect($sformatf("vec%0d", i), 1, exp_latency(vecs[i].code));
    end

    // MUL with in_valid held during CALC: must be ignored
    exp_q.push_back({32'h0000_0006, 1'b0, 1'b0, 1'b0});
    drive_op(4'b1000, 32'h0000_0002, 32'h0000_0003);
    alu_cnt = 4'b0000; src_a = 32'h1; src_b = 32'h1; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("calc_busy", busy, 1);
    check("calc_in_ready", in_ready, 0);
    in_valid = 1'b0;
    collect("mul_hold", 5, W + 1);

    // Back-to-back ADD then OR with in_valid held
    alu_cnt = 4'b0000; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("b2b_first_valid", out_valid, 1);
    check("b2b_first_result", result, 32'd7);
    check("b2b_in_ready", in_ready, 1);
    alu_cnt = 4'b0011; src_a = 32'h0000_00F0; src_b = 32'h0000_000F;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_second_valid", out_valid, 1);
    check("b2b_second_result", result, 32'h0000_00FF);
    @(negedge clk);
    check("b2b_drained", out_valid, 0);

    // Backpressure: result held, no new accept for 5 cycles
    out_ready = 1'b0;
    drive_op(4'b0100, 32'h0000_1234, 32'h0000_00FF);
    alu_cnt = 4'b0000; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid_%0d", k), out_valid, 1);
      check($sformatf("bp_result_%0d", k), result, 32'h0000_12CB);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_result", result, 32'd2);
    check("bp_next_valid", out_valid, 1);
    @(negedge clk);

    // Asynchronous reset in the middle of a MUL
    drive_op(4'b1000, 32'h0001_0003, 32'h0000_0004);
    repeat (9) @(negedge clk);
    check("midmul_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit is usable again after the reset
    exp_q.push_back({32'h0000_0010, 1'b0, 1'b0, 1'b0});
    drive_op(4'b0101, 32'h0000_0001, 32'h0000_0004);
    collect("post_reset", 1, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
